// File: rtl/fir_mix_pkg.sv
// Shared types, widths and the round/saturate helper for the FIR equalizer mixer.
package fir_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int GAIN_W   = 16;
  localparam int BAND_W   = 48;
  localparam int OUT_W    = 24;
  localparam int PROD_W   = 64;
  // Widest accumulator: 64-bit products summed over up to 64 bands.
  localparam int RS_ACC_W = 70;

  localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h4000;

  localparam logic signed [RS_ACC_W:0] SAT_MAX = (RS_ACC_W+1)'(8388607);
  localparam logic signed [RS_ACC_W:0] SAT_MIN = (RS_ACC_W+1)'(-8388608);

  // Round half up, arithmetic shift right, clamp to the 24-bit signed range.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [RS_ACC_W-1:0] acc,
                                                 input int shift);
    logic signed [RS_ACC_W:0] half;
    logic signed [RS_ACC_W:0] sum;
    logic signed [RS_ACC_W:0] shr;
    half = (RS_ACC_W+1)'(1) <<< (shift - 1);
    sum  = (RS_ACC_W+1)'(acc) + half;
    shr  = sum >>> shift;
    if (shr > SAT_MAX) begin
      return 24'h7FFFFF;
    end else if (shr < SAT_MIN) begin
      return 24'h800000;
    end else begin
      return shr[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_mix_mac.sv
// One channel of the mixer: band snapshot, band x gain accumulator, and rounded output register.
module fir_mix_mac
  import fir_mix_pkg::*;
#(
  parameter int NUM_BANDS = 4,
  parameter int ACC_SHIFT = 29,
  parameter int IDX_W     = 2,
  parameter int ACC_W     = 66
) (
  input  logic              clk,
  input  logic              clr_out,
  input  logic              capture,
  input  logic              accum_en,
  input  logic              load_out,
  input  logic              mute,
  input  logic [IDX_W-1:0]  idx,
  input  logic [GAIN_W-1:0] gain,
  input  logic [BAND_W-1:0] band_in [NUM_BANDS-1:0],
  output logic [OUT_W-1:0]  sample_out
);

  logic [BAND_W-1:0]        snap_q [NUM_BANDS-1:0];
  logic [BAND_W-1:0]        snap_d [NUM_BANDS-1:0];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic signed [PROD_W-1:0] snap_ext, gain_ext, prod;

  always_comb begin
    snap_ext = PROD_W'($signed(snap_q[idx]));
    gain_ext = PROD_W'($signed(gain));
    prod     = snap_ext * gain_ext;

    snap_d = snap_q;
    acc_d  = acc_q;
    out_d  = out_q;

    if (capture) begin
      snap_d = band_in;
      acc_d  = '0;
    end else if (accum_en) begin
      acc_d = acc_q + ACC_W'(prod);
    end

    // Output register is cleared by reset/abort; snapshot and accumulator are reloaded on capture.
    if (clr_out) begin
      out_d = '0;
    end else if (load_out) begin
      out_d = mute ? '0 : round_sat(RS_ACC_W'(acc_q), ACC_SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    acc_q  <= acc_d;
    out_q  <= out_d;
  end

  assign sample_out = out_q;

endmodule

// File: rtl/fir_eq_mixer.sv
// Stereo FIR band mixer: per-band gain, band sum, round/saturate to 24 bits, valid/ready output.
module fir_eq_mixer
  import fir_mix_pkg::*;
#(
  parameter int NUM_BANDS = 4,
  parameter int ACC_SHIFT = 29
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              audio_en,
  input  logic              fir_valid,
  input  logic [BAND_W-1:0] l_band_in [NUM_BANDS-1:0],
  input  logic [BAND_W-1:0] r_band_in [NUM_BANDS-1:0],
  input  logic              gain_wr_en,
  input  logic [5:0]        gain_select,
  input  logic [GAIN_W-1:0] gain_wr_data,
  input  logic              mute,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  l_out,
  output logic [OUT_W-1:0]  r_out,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int ACC_W = PROD_W + $clog2(NUM_BANDS);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mute_q, mute_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic [GAIN_W-1:0] gain_sh_q  [NUM_BANDS-1:0];
  logic [GAIN_W-1:0] gain_sh_d  [NUM_BANDS-1:0];
  logic [GAIN_W-1:0] gain_act_q [NUM_BANDS-1:0];
  logic [GAIN_W-1:0] gain_act_d [NUM_BANDS-1:0];
  logic              capture, accum_en, load_out, clr_out;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mute_d      = mute_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    gain_sh_d   = gain_sh_q;
    gain_act_d  = gain_act_q;
    capture     = 1'b0;
    accum_en    = 1'b0;
    load_out    = 1'b0;
    clr_out     = 1'b0;

    if (gain_wr_en && ({1'b0, gain_select} < 7'(NUM_BANDS))) begin
      gain_sh_d[gain_select[IDX_W-1:0]] = gain_wr_data;
    end

    // A set on the same edge as a clear takes priority.
    if (overrun_clr) overrun_d = 1'b0;
    if (fir_valid && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fir_valid) begin
          capture    = 1'b1;
          gain_act_d = gain_sh_q;
          mute_d     = mute;
          idx_d      = '0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        accum_en = 1'b1;
        if (idx_q == IDX_W'(NUM_BANDS - 1)) begin
          state_d = ST_ROUND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ROUND: begin
        load_out    = 1'b1;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // audio_en low aborts like reset but keeps the gain sets.
    if (!reset_n || !audio_en) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      mute_d      = 1'b0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      capture     = 1'b0;
      accum_en    = 1'b0;
      load_out    = 1'b0;
      clr_out     = 1'b1;
    end
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        gain_sh_d[b]  = UNITY_GAIN;
        gain_act_d[b] = UNITY_GAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    idx_q       <= idx_d;
    mute_q      <= mute_d;
    out_valid_q <= out_valid_d;
    overrun_q   <= overrun_d;
    gain_sh_q   <= gain_sh_d;
    gain_act_q  <= gain_act_d;
  end

  fir_mix_mac #(
    .NUM_BANDS(NUM_BANDS),
    .ACC_SHIFT(ACC_SHIFT),
    .IDX_W    (IDX_W),
    .ACC_W    (ACC_W)
  ) u_mac_l (
    .clk       (clk),
    .clr_out   (clr_out),
    .capture   (capture),
    .accum_en  (accum_en),
    .load_out  (load_out),
    .mute      (mute_q),
    .idx       (idx_q),
    .gain      (gain_act_q[idx_q]),
    .band_in   (l_band_in),
    .sample_out(l_out)
  );

  fir_mix_mac #(
    .NUM_BANDS(NUM_BANDS),
    .ACC_SHIFT(ACC_SHIFT),
    .IDX_W    (IDX_W),
    .ACC_W    (ACC_W)
  ) u_mac_r (
    .clk       (clk),
    .clr_out   (clr_out),
    .capture   (capture),
    .accum_en  (accum_en),
    .load_out  (load_out),
    .mute      (mute_q),
    .idx       (idx_q),
    .gain      (gain_act_q[idx_q]),
    .band_in   (r_band_in),
    .sample_out(r_out)
  );

  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_eq_mixer.sv
// Directed bench for fir_eq_mixer: vector table plus handshake, shadow-gain and abort sequences.
module tb_fir_eq_mixer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset_n, audio_en, fir_valid, gain_wr_en, mute, out_ready, overrun_clr;
  logic [5:0]  gain_select;
  logic [15:0] gain_wr_data;
  logic [47:0] l_band_in [NB-1:0];
  logic [47:0] r_band_in [NB-1:0];
  logic        out_valid, busy, overrun;
  logic [23:0] l_out, r_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [NB-1:0][47:0] l;
    logic [NB-1:0][47:0] r;
    logic                mute;
    logic [23:0]         el;
    logic [23:0]         er;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  fir_eq_mixer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .audio_en    (audio_en),
    .fir_valid   (fir_valid),
    .l_band_in   (l_band_in),
    .r_band_in   (r_band_in),
    .gain_wr_en  (gain_wr_en),
    .gain_select (gain_select),
    .gain_wr_data(gain_wr_data),
    .mute        (mute),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .l_out       (l_out),
    .r_out       (r_out),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  function automatic logic [47:0] sc(input longint x);
    return 48'(x * 64'sd32768);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply_bands(input vec_t v);
    for (int b = 0; b < NB; b++) begin
      l_band_in[b] = v.l[b];
      r_band_in[b] = v.r[b];
    end
    mute = v.mute;
  endtask

  task automatic launch();
    fir_valid = 1'b1;
    @(posedge clk); #1;
    fir_valid = 1'b0;
    mute      = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid_low", 32'(out_valid), 32'd0);
    check("hs_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic gain_write(input logic [5:0] sel, input logic [15:0] d);
    gain_wr_en   = 1'b1;
    gain_select  = sel;
    gain_wr_data = d;
    @(posedge clk); #1;
    gain_wr_en   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    vec_t g;

    for (int i = 0; i < 8; i++) vecs[i] = '0;
    vecs[0].l[0] = sc(1000);     vecs[0].r[0] = sc(-1000);
    vecs[0].el = 24'h0003E8;     vecs[0].er = 24'hFFFC18;
    for (int b = 0; b < NB; b++) begin
      vecs[1].l[b] = sc(3000000);
      vecs[1].r[b] = sc(-3000000);
    end
    vecs[1].el = 24'h7FFFFF;     vecs[1].er = 24'h800000;
    vecs[2].l[0] = 48'd16384;    vecs[2].r[0] = 48'(-64'sd16384);
    vecs[2].el = 24'h000001;     vecs[2].er = 24'h000000;
    vecs[3].l[0] = 48'd49152;    vecs[3].r[0] = 48'(-64'sd49152);
    vecs[3].el = 24'h000002;     vecs[3].er = 24'hFFFFFF;
    vecs[4].l[0] = sc(1000);     vecs[4].r[0] = sc(-1000);   vecs[4].mute = 1'b1;
    vecs[4].el = 24'h000000;     vecs[4].er = 24'h000000;
    vecs[5].l[0] = sc(100);  vecs[5].l[1] = sc(200); vecs[5].l[2] = sc(300); vecs[5].l[3] = sc(400);
    vecs[5].r[0] = sc(-5);   vecs[5].r[1] = sc(10);  vecs[5].r[2] = sc(0);   vecs[5].r[3] = sc(1);
    vecs[5].el = 24'h0003E8;     vecs[5].er = 24'h000006;
    vecs[6].l[0] = sc(8388607);  vecs[6].r[0] = sc(-8388609);
    vecs[6].el = 24'h7FFFFF;     vecs[6].er = 24'h800000;
    vecs[7].l[0] = sc(-8388608); vecs[7].r[0] = sc(8388608);
    vecs[7].el = 24'h800000;     vecs[7].er = 24'h7FFFFF;

    reset_n = 1'b0; audio_en = 1'b1; fir_valid = 1'b0; gain_wr_en = 1'b0; mute = 1'b0;
    out_ready = 1'b0; overrun_clr = 1'b0; gain_select = '0; gain_wr_data = '0;
    apply_bands('0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_l", 32'(l_out), 32'd0);
    check("rst_r", 32'(r_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      apply_bands(vecs[i]);
      launch();
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_out(n);
      check($sformatf("v%0d_latency", i), 32'(n), 32'd5);
      check($sformatf("v%0d_l", i), 32'(l_out), 32'(vecs[i].el));
      check($sformatf("v%0d_r", i), 32'(r_out), 32'(vecs[i].er));
      handshake();
    end

    // Shadow gains: a write mid-frame only shows up in the following frame.
    g = '0;
    g.l[0] = sc(1000);
    apply_bands(g);
    launch();
    gain_write(6'd0, 16'h2000);
    wait_out(n);
    check("shadow_same_frame", 32'(l_out), 32'd1000);
    handshake();
    launch();
    wait_out(n);
    check("shadow_next_frame", 32'(l_out), 32'd500);
    handshake();
    gain_write(6'd0, 16'h4000);
    gain_write(6'd9, 16'h0000);
    g.l[1] = sc(1000);
    apply_bands(g);
    launch();
    wait_out(n);
    check("sel_oob_ignored", 32'(l_out), 32'd2000);
    handshake();

    // Backpressure with overrun attempts while the sample is held.
    g = '0;
    g.l[0] = sc(1000);
    g.r[0] = sc(-1000);
    apply_bands(g);
    launch();
    wait_out(n);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        g.l[0] = sc(7777);
        apply_bands(g);
        fir_valid = 1'b1;
      end
      if (c == 10) begin
        fir_valid   = 1'b1;
        overrun_clr = 1'b1;
      end
      @(posedge clk); #1;
      fir_valid   = 1'b0;
      overrun_clr = 1'b0;
      check($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_l_c%0d", c), 32'(l_out), 32'd1000);
      check($sformatf("bp_r_c%0d", c), 32'(r_out), 32'hFFFC18);
      if (c == 4)  check("ov_before", 32'(overrun), 32'd0);
      if (c == 5)  check("ov_set", 32'(overrun), 32'd1);
      if (c == 10) check("ov_set_beats_clr", 32'(overrun), 32'd1);
    end
    handshake();
    repeat (10) @(posedge clk);
    #1;
    check("no_second_out", 32'(out_valid), 32'd0);
    check("no_second_busy", 32'(busy), 32'd0);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    check("ov_cleared", 32'(overrun), 32'd0);

    // fir_valid on the handshake edge is an overrun and the frame is dropped.
    launch();
    wait_out(n);
    out_ready = 1'b1;
    fir_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fir_valid = 1'b0;
    check("hs_edge_overrun", 32'(overrun), 32'd1);
    check("hs_edge_busy", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("hs_edge_dropped", 32'(out_valid), 32'd0);

    // Reset mid-ACCUM: outputs cleared and gains return to unity.
    gain_write(6'd0, 16'h2000);
    g = '0;
    g.l[0] = sc(1000);
    apply_bands(g);
    launch();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_rst_valid", 32'(out_valid), 32'd0);
    check("abort_rst_l", 32'(l_out), 32'd0);
    check("abort_rst_r", 32'(r_out), 32'd0);
    check("abort_rst_busy", 32'(busy), 32'd0);
    check("abort_rst_overrun", 32'(overrun), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_rst_no_out", 32'(out_valid), 32'd0);
    launch();
    wait_out(n);
    check("after_rst_unity", 32'(l_out), 32'd1000);
    handshake();

    // audio_en low mid-ACCUM: same abort, but shadow gains survive.
    gain_write(6'd0, 16'h2000);
    launch();
    @(posedge clk); #1;
    audio_en = 1'b0;
    @(posedge clk); #1;
    audio_en = 1'b1;
    check("abort_en_valid", 32'(out_valid), 32'd0);
    check("abort_en_l", 32'(l_out), 32'd0);
    check("abort_en_busy", 32'(busy), 32'd0);
    launch();
    wait_out(n);
    check("after_en_gain_kept", 32'(l_out), 32'd500);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_eq_mixer.md
# fir_eq_mixer

Downstream stage of the stereo FIR equalizer bank. Captures the per-band 48-bit FIR accumulator outputs for left and right on the FIR valid strobe and applies a programmable per-band gain. It sums the bands, rounds and saturates the result to 24-bit, then holds each stereo sample behind a valid/ready handshake for the I2S transmit path.

## Interface
- NUM_BANDS, 4: number of FIR bands per channel (1..64).
- ACC_SHIFT, 29: right shift applied to the band×gain sum (15 FIR coefficient fraction bits + 14 gain fraction bits).
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- audio_en  in  1  low aborts any frame in flight, like reset; gains are kept.
- fir_valid  in  1  one-clock strobe: band inputs are valid.
- l_band_in  in  48×NUM_BANDS  signed left band outputs, unpacked array [NUM_BANDS-1:0].
- r_band_in  in  48×NUM_BANDS  signed right band outputs, unpacked array [NUM_BANDS-1:0].
- gain_wr_en  in  1  write strobe into the gain shadow set.
- gain_select  in  6  band index to write; index ≥ NUM_BANDS is ignored.
- gain_wr_data  in  16  signed Q2.14 gain; unity is 16'h4000.
- mute  in  1  forces result to 0; sampled at capture.
- out_ready  in  1  consumer accepts the sample.
- out_valid  out  1  l_out/r_out hold a valid sample.
- l_out  out  24  signed left sample.
- r_out  out  24  signed right sample.
- busy  out  1  state ≠ IDLE.
- overrun  out  1  sticky: a fir_valid arrived outside IDLE.
- overrun_clr  in  1  clears overrun; a new overrun on the same edge wins.

## Operation
- The block has four states: IDLE, ACCUM, ROUND, OUT.
- **IDLE**, on fir_valid:
  - Snapshot all 2×NUM_BANDS band inputs.
  - Copy the shadow gains into the active gains.
  - Latch mute.
  - Clear both accumulators and set band index to 0.
  - Go to ACCUM.
- **ACCUM**, one band per clock, both channels in parallel:
  - acc += snap[idx] × active_gain[idx], full-precision signed product of 64 bits.
  - Accumulator width is 64 + clog2(NUM_BANDS) bits, so it never wraps.
  - When idx == NUM_BANDS-1, go to ROUND.
- **ROUND**:
  - r = (acc + 2^(ACC_SHIFT-1)) >>> ACC_SHIFT, arithmetic shift, round half up.
  - Saturate to [-8388608, 8388607], i.e. 24'h800000 / 24'h7FFFFF.
  - If mute was latched, the result is 0.
  - Register the result on l_out/r_out, set out_valid, go to OUT.
- **OUT**:
  - l_out, r_out and out_valid are held stable until the edge where out_valid && out_ready.
  - On that edge, clear out_valid and go to IDLE.
- **Overrun**: fir_valid in any state other than IDLE (including the OUT handshake edge) drops that frame and sets overrun.
- **Gain writes**:
  - Accepted in any state; they always write the shadow set only.
  - The frame in progress is unaffected.
- **Reset** (reset_n low), including mid-frame:
  - State → IDLE, out_valid = 0, l_out = r_out = 0, overrun = 0, busy = 0.
  - Shadow and active gains → 16'h4000.
- **audio_en low**: same as reset except gains are kept.

## Timing
- fir_valid sampled at edge k → ACCUM edges k+1..k+NUM_BANDS → ROUND edge k+NUM_BANDS+1.
- out_valid is high after edge k+NUM_BANDS+1, i.e. latency NUM_BANDS+1 clocks (5 at default).
- Minimum frame period is NUM_BANDS+3 clocks with out_ready tied high.
- busy rises after edge k; it falls after the handshake edge.
- overrun sets on the edge after the offending fir_valid.

## Structure
- Package fir_mix_pkg holds:
  - the state enum;
  - UNITY_GAIN = 16'h4000, GAIN_W = 16, BAND_W = 48, OUT_W = 24;
  - the round_sat function, parameterised by ACC_SHIFT.
- Sub-module fir_mix_mac: one channel's snapshot, accumulator and round/saturate, instantiated twice (left, right) under a shared control FSM and shared gain registers.

## Test plan
- **Unity gain, single band**: default gains; l_band_in[0] = 1000·2^15, r_band_in[0] = -1000·2^15, other bands 0; pulse fir_valid → 5 clocks later out_valid, l_out = 1000, r_out = -1000.
- **Saturation**: all 4 bands = 3000000·2^15 → l_out = 24'h7FFFFF; all bands negated → 24'h800000.
- **Rounding**: band0 = 2^14 → 1; band0 = -2^14 → 0; band0 = 3·2^14 → 2.
- **Gain shadowing**:
  - Write gain 16'h2000 to band 0 during ACCUM → that frame outputs 1000; the next frame outputs 500.
  - Write with gain_select = 9 → no effect.
- **Backpressure/overrun**:
  - Hold out_ready low 20 clocks and pulse fir_valid meanwhile → out_valid and data stay stable, overrun = 1, no second output.
  - Pulse overrun_clr → overrun = 0.
- **Abort**: reset_n low for 1 clock during ACCUM → out_valid = 0, outputs 0, busy = 0; a subsequent frame uses gain 16'h4000.
